// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the memory cycle sequencer: FSM state encoding,
// pending-request kinds, parameter defaults and odd-parity helpers.
package memory_cycle_pkg;

    localparam int unsigned DEF_WORD_W   = 16;
    localparam int unsigned DEF_EADDR_W  = 11;
    localparam int unsigned DEF_FADDR_W  = 16;
    localparam int unsigned DEF_READ_LAT = 2;

    // Parity helpers operate on a zero-extended word; zero padding leaves the XOR unchanged.
    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        E_READ,
        E_WRITE,
        F_READ,
        F_SENSE
    } state_e;

    typedef enum logic {
        REQ_ERASABLE = 1'b0,
        REQ_FIXED    = 1'b1
    } req_kind_e;

    // A word is good when its count of ones is odd.
    function automatic logic parity_good(input logic [PAR_MAX_W-1:0] w);
        return ^w;
    endfunction

    // Parity bit that makes the total count of ones odd.
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-deep holding slot for a memory request that arrives while a cycle is running.
// A load in the same cycle as a clear wins, so a freed slot can be refilled at once.
module mem_req_slot
    import memory_cycle_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_FADDR_W,
    parameter int unsigned DATA_W = DEF_WORD_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              ld_fixed,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_wen,
    input  logic [DATA_W-1:0] ld_data,
    output logic              full,
    output logic              fixed,
    output logic [ADDR_W-1:0] addr,
    output logic              wen,
    output logic [DATA_W-1:0] data
);

    logic              full_q, full_d;
    req_kind_e         kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        kind_d = kind_q;
        addr_d = addr_q;
        wen_d  = wen_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            kind_d = ld_fixed ? REQ_FIXED : REQ_ERASABLE;
            addr_d = ld_addr;
            wen_d  = ld_wen;
            data_d = ld_data;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            kind_q <= REQ_ERASABLE;
            addr_q <= '0;
            wen_q  <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            kind_q <= kind_d;
            addr_q <= addr_d;
            wen_q  <= wen_d;
            data_q <= data_d;
        end
    end

    assign full  = full_q;
    assign fixed = (kind_q == REQ_FIXED);
    assign addr  = addr_q;
    assign wen   = wen_q;
    assign data  = data_q;

endmodule

// File: rtl/memory_cycle_sequencer.sv
// Sequences erasable read/write-back cycles and fixed read cycles onto a shared
// memory port, with a one-deep pending request slot and registered outputs.
module memory_cycle_sequencer
    import memory_cycle_pkg::*;
#(
    parameter int unsigned WORD_W   = DEF_WORD_W,
    parameter int unsigned EADDR_W  = DEF_EADDR_W,
    parameter int unsigned FADDR_W  = DEF_FADDR_W,
    parameter int unsigned READ_LAT = DEF_READ_LAT
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic               SETEK,
    input  logic               SBF,
    input  logic               WEN,
    input  logic [EADDR_W-1:0] EADDR,
    input  logic [FADDR_W-1:0] FADDR,
    input  logic [WORD_W-1:0]  GEM,
    input  logic               CLROPE,
    output logic               MEM_SEL,
    output logic [FADDR_W-1:0] MEM_ADDR,
    output logic               MEM_RE,
    output logic               MEM_WE,
    output logic [WORD_W-1:0]  MEM_WDATA,
    input  logic [WORD_W-1:0]  MEM_RDATA,
    output logic [WORD_W-1:0]  SA,
    output logic               SA_VALID,
    output logic               PERR,
    output logic               BUSY,
    output logic               OVERRUN
);

    localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cur_wen_q, cur_wen_d;
    logic [WORD_W-2:0]   cur_data_q, cur_data_d;
    logic                mem_sel_q, mem_sel_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [FADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d, sa_q, sa_d;
    logic                sa_valid_q, sa_valid_d, perr_q, perr_d;
    logic                busy_q, busy_d, overrun_q, overrun_d;

    logic                slot_full, slot_fixed, slot_wen;
    logic [FADDR_W-1:0]  slot_addr;
    logic [WORD_W-2:0]   slot_data;
    logic                slot_load, slot_clear, ld_fixed;
    logic [FADDR_W-1:0]  ld_addr, e_addr;
    logic                sbf_go, cancel, pend, launch, start_new, slot_free, drop, slot_full_nx;
    logic                cyc_fixed, cyc_wen;
    logic [FADDR_W-1:0]  cyc_addr;
    logic [WORD_W-2:0]   cyc_data;

    // The parity bit of GEM is discarded; a fresh one is generated on write.
    logic unused_gem_parity;
    assign unused_gem_parity = GEM[WORD_W-1];

    mem_req_slot #(
        .ADDR_W (FADDR_W),
        .DATA_W (WORD_W - 1)
    ) u_slot (
        .clk      (SIM_CLK),
        .rst_n    (SIM_RST),
        .load     (slot_load),
        .clear    (slot_clear),
        .ld_fixed (ld_fixed),
        .ld_addr  (ld_addr),
        .ld_wen   (WEN),
        .ld_data  (GEM[WORD_W-2:0]),
        .full     (slot_full),
        .fixed    (slot_fixed),
        .addr     (slot_addr),
        .wen      (slot_wen),
        .data     (slot_data)
    );

    // Arrival handling: CLROPE beats a pending fixed launch; a slot being launched
    // from IDLE is free for a new arrival in the same cycle; SETEK outranks SBF.
    always_comb begin
        sbf_go    = SBF && !CLROPE;
        cancel    = CLROPE && slot_full && slot_fixed;
        pend      = slot_full && !cancel;
        launch    = (state_q == IDLE) && pend;
        start_new = (state_q == IDLE) && !pend && (SETEK || sbf_go);
        slot_free = !pend || launch;
        e_addr    = FADDR_W'(EADDR);

        if (launch) begin
            cyc_fixed = slot_fixed;
            cyc_addr  = slot_addr;
            cyc_wen   = slot_wen;
            cyc_data  = slot_data;
        end else begin
            cyc_fixed = !SETEK;
            cyc_addr  = SETEK ? e_addr : FADDR;
            cyc_wen   = WEN;
            cyc_data  = GEM[WORD_W-2:0];
        end

        slot_load = 1'b0;
        ld_fixed  = !SETEK;
        ld_addr   = SETEK ? e_addr : FADDR;
        drop      = 1'b0;
        if (start_new) begin
            slot_load = SETEK && sbf_go;
            ld_fixed  = 1'b1;
            ld_addr   = FADDR;
        end else if (slot_free) begin
            slot_load = SETEK || sbf_go;
            drop      = SETEK && sbf_go;
        end else begin
            drop      = SETEK || sbf_go;
        end
        slot_clear   = cancel || launch;
        slot_full_nx = slot_load || (pend && !launch);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_wen_d   = cur_wen_q;
        cur_data_d  = cur_data_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        sa_d        = sa_q;
        sa_valid_d  = 1'b0;
        perr_d      = perr_q;

        case (state_q)
            IDLE: begin
                if (launch || start_new) begin
                    state_d    = cyc_fixed ? F_READ : E_READ;
                    cnt_d      = CNT_W'(READ_LAT - 1);
                    cur_wen_d  = cyc_wen;
                    cur_data_d = cyc_data;
                    mem_sel_d  = cyc_fixed;
                    mem_addr_d = cyc_addr;
                    mem_re_d   = 1'b1;
                end
            end
            E_READ, F_READ: begin
                if (cnt_q == '0) begin
                    sa_d       = MEM_RDATA;
                    sa_valid_d = 1'b1;
                    perr_d     = !parity_good(PAR_MAX_W'(MEM_RDATA));
                    if (state_q == E_READ) begin
                        state_d     = E_WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = cur_wen_q ? {parity_bit(PAR_MAX_W'(cur_data_q)), cur_data_q}
                                                : MEM_RDATA;
                    end else begin
                        state_d = F_SENSE;
                    end
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_re_d = 1'b1;
                end
            end
            E_WRITE, F_SENSE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE) || slot_full_nx;
        overrun_d = overrun_q || drop;
    end

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_wen_q   <= 1'b0;
            cur_data_q  <= '0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            sa_q        <= '0;
            sa_valid_q  <= 1'b0;
            perr_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_wen_q   <= cur_wen_d;
            cur_data_q  <= cur_data_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            sa_q        <= sa_d;
            sa_valid_q  <= sa_valid_d;
            perr_q      <= perr_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign MEM_SEL   = mem_sel_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_RE    = mem_re_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WDATA = mem_wdata_q;
    assign SA        = sa_q;
    assign SA_VALID  = sa_valid_q;
    assign PERR      = perr_q;
    assign BUSY      = busy_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_memory_cycle_sequencer.sv
// Bench for memory_cycle_sequencer: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_memory_cycle_sequencer;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n, setek, sbf, wen, clrope;
    logic [10:0] eaddr;
    logic [15:0] faddr, gem, rdata;
    logic        mem_sel, mem_re, mem_we, sa_valid, perr, busy, overrun;
    logic [15:0] mem_addr, mem_wdata, sa;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_cycle_sequencer #(
        .WORD_W   (16),
        .EADDR_W  (11),
        .FADDR_W  (16),
        .READ_LAT (RL)
    ) dut (
        .SIM_CLK   (clk),
        .SIM_RST   (rst_n),
        .SETEK     (setek),
        .SBF       (sbf),
        .WEN       (wen),
        .EADDR     (eaddr),
        .FADDR     (faddr),
        .GEM       (gem),
        .CLROPE    (clrope),
        .MEM_SEL   (mem_sel),
        .MEM_ADDR  (mem_addr),
        .MEM_RE    (mem_re),
        .MEM_WE    (mem_we),
        .MEM_WDATA (mem_wdata),
        .MEM_RDATA (rdata),
        .SA        (sa),
        .SA_VALID  (sa_valid),
        .PERR      (perr),
        .BUSY      (busy),
        .OVERRUN   (overrun)
    );

    typedef struct {
        logic [4:0]  ib;    // {rst_n, setek, sbf, wen, clrope}
        logic [10:0] ea;
        logic [15:0] fa, g, rd;
        logic [5:0]  eb;    // {re, we, sa_valid, busy, overrun, sel}
        logic [15:0] ad, s, wd;
        logic        pe;
    } vec_t;

    typedef struct {
        bit          fixed;
        logic [15:0] addr;
        logic        wen;
        logic [15:0] gem;
    } req_t;

    vec_t vecs[$];

    // reference model state
    int          m_age;     // 0 = idle, 1..RL = read cycle, RL+1 = write/sense cycle
    req_t        m_cur, m_pend;
    bit          m_pend_v, m_ovr, m_perr;
    logic [15:0] m_sa, m_wdata;

    function automatic vec_t mk(input logic [4:0] ib, input logic [10:0] ea,
                                input logic [15:0] fa, g, rd, input logic [5:0] eb,
                                input logic [15:0] ad, s, wd, input logic pe);
        vec_t v;
        v.ib = ib; v.ea = ea; v.fa = fa; v.g = g; v.rd = rd;
        v.eb = eb; v.ad = ad; v.s = s; v.wd = wd; v.pe = pe;
        return v;
    endfunction

    function automatic logic [15:0] with_parity(input logic [15:0] g);
        logic [15:0] d;
        d = g & 16'h7FFF;
        return ($countones(d) % 2 == 0) ? (d | 16'h8000) : d;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst_n = 1'b1; setek = 1'b0; sbf = 1'b0; wen = 1'b0; clrope = 1'b0;
        eaddr = '0; faddr = '0; gem = '0; rdata = '0;
    endtask

    task automatic model_edge();
        req_t arr[$];
        req_t r;
        if (!rst_n) begin
            m_age = 0; m_pend_v = 0; m_sa = '0; m_perr = 0; m_ovr = 0;
            return;
        end
        if (setek) begin
            r.fixed = 0; r.addr = 16'(eaddr); r.wen = wen; r.gem = gem;
            arr.push_back(r);
        end
        if (sbf && !clrope) begin
            r.fixed = 1; r.addr = faddr; r.wen = 1'b0; r.gem = '0;
            arr.push_back(r);
        end
        if (clrope && m_pend_v && m_pend.fixed) m_pend_v = 0;
        if (m_age == 0) begin
            if (m_pend_v) begin
                m_cur = m_pend; m_pend_v = 0; m_age = 1;
            end else if (arr.size() > 0) begin
                m_cur = arr.pop_front(); m_age = 1;
            end
        end else if (m_age == RL + 1) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == RL + 1) begin
                m_sa    = rdata;
                m_perr  = ($countones(rdata) % 2 == 0);
                m_wdata = m_cur.wen ? with_parity(m_cur.gem) : rdata;
            end
        end
        foreach (arr[i]) begin
            if (!m_pend_v) begin
                m_pend = arr[i]; m_pend_v = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    initial begin
        // erasable restore, erasable write (incl. ignored GEM parity bit), SETEK+SBF together
        vecs.push_back(mk(5'b11000, 11'h123, 16'h0000, 16'h0000, 16'h0000, 6'b100100, 16'h0123, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'hFFFF, 6'b100100, 16'h0123, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0001, 6'b011100, 16'h0000, 16'h0001, 16'h0001, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b11010, 11'h7FF, 16'h0000, 16'h0003, 16'h0000, 6'b100100, 16'h07FF, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b100100, 16'h07FF, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h1234, 6'b011100, 16'h0000, 16'h1234, 16'h8003, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h1234, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b11010, 11'h000, 16'h0000, 16'h8007, 16'h0000, 6'b100100, 16'h0000, 16'h1234, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b100100, 16'h0000, 16'h1234, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b011100, 16'h0000, 16'h0000, 16'h0007, 1'b1));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(5'b11100, 11'h055, 16'hABCD, 16'h0000, 16'h0000, 6'b100100, 16'h0055, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b100100, 16'h0055, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0001, 6'b011100, 16'h0000, 16'h0001, 16'h0001, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b000100, 16'h0000, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b100101, 16'hABCD, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b100101, 16'hABCD, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0003, 6'b001101, 16'h0000, 16'h0003, 16'h0000, 1'b1));
        vecs.push_back(mk(5'b10000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0003, 16'h0000, 1'b1));

        quiet();
        rst_n = 1'b0;
        tick(); tick();
        chk1("rst_re", mem_re, 1'b0);       chk1("rst_we", mem_we, 1'b0);
        chk1("rst_sv", sa_valid, 1'b0);     chk1("rst_busy", busy, 1'b0);
        chk1("rst_ovr", overrun, 1'b0);     chk1("rst_perr", perr, 1'b0);
        chk1("rst_sel", mem_sel, 1'b0);     chk16("rst_addr", mem_addr, 16'h0000);
        chk16("rst_sa", sa, 16'h0000);      chk16("rst_wdata", mem_wdata, 16'h0000);

        foreach (vecs[i]) begin
            {rst_n, setek, sbf, wen, clrope} = vecs[i].ib;
            eaddr = vecs[i].ea; faddr = vecs[i].fa; gem = vecs[i].g; rdata = vecs[i].rd;
            tick();
            chk1($sformatf("vec%0d_re", i), mem_re, vecs[i].eb[5]);
            chk1($sformatf("vec%0d_we", i), mem_we, vecs[i].eb[4]);
            chk1($sformatf("vec%0d_sv", i), sa_valid, vecs[i].eb[3]);
            chk1($sformatf("vec%0d_busy", i), busy, vecs[i].eb[2]);
            chk1($sformatf("vec%0d_ovr", i), overrun, vecs[i].eb[1]);
            chk16($sformatf("vec%0d_sa", i), sa, vecs[i].s);
            chk1($sformatf("vec%0d_perr", i), perr, vecs[i].pe);
            if (vecs[i].eb[5]) begin
                chk1($sformatf("vec%0d_sel", i), mem_sel, vecs[i].eb[0]);
                chk16($sformatf("vec%0d_addr", i), mem_addr, vecs[i].ad);
            end
            if (vecs[i].eb[4]) chk16($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wd);
        end

        // overrun: SETEK, SBF, SETEK on consecutive edges
        quiet();
        setek = 1'b1; eaddr = 11'h001; tick(); quiet();
        sbf = 1'b1; faddr = 16'h0042; tick(); quiet();
        setek = 1'b1; eaddr = 11'h002; tick(); quiet();
        chk1("ovr_set", overrun, 1'b1);  chk1("ovr_we", mem_we, 1'b1);
        tick();
        chk1("ovr_gap_busy", busy, 1'b1); chk1("ovr_gap_re", mem_re, 1'b0);
        tick();
        chk1("ovr_f_re", mem_re, 1'b1); chk1("ovr_f_sel", mem_sel, 1'b1);
        chk16("ovr_f_addr", mem_addr, 16'h0042);
        tick(); tick();
        chk1("ovr_f_sv", sa_valid, 1'b1); chk1("ovr_f_we", mem_we, 1'b0);
        tick();
        chk1("ovr_end_busy", busy, 1'b0);
        tick();
        chk1("ovr_dropped_re", mem_re, 1'b0); chk1("ovr_sticky", overrun, 1'b1);
        rst_n = 1'b0; tick(); quiet();
        chk1("ovr_rst_clear", overrun, 1'b0);

        // reset in the middle of an erasable cycle
        setek = 1'b1; eaddr = 11'h005; wen = 1'b1; gem = 16'h0001; tick(); quiet();
        chk1("mid_rst_started", mem_re, 1'b1);
        rst_n = 1'b0; tick(); quiet();
        chk1("mid_rst_re", mem_re, 1'b0); chk1("mid_rst_busy", busy, 1'b0);
        chk16("mid_rst_sa", sa, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1($sformatf("mid_rst_we%0d", c), mem_we, 1'b0);
            chk1($sformatf("mid_rst_sv%0d", c), sa_valid, 1'b0);
            chk1($sformatf("mid_rst_idle_re%0d", c), mem_re, 1'b0);
        end

        // CLROPE empties a pending fixed request
        setek = 1'b1; tick(); quiet();
        sbf = 1'b1; faddr = 16'h0099; tick(); quiet();
        clrope = 1'b1; tick(); quiet();
        tick(); tick();
        chk1("clr_f_busy", busy, 1'b0);
        tick();
        chk1("clr_f_re", mem_re, 1'b0);

        // SBF together with CLROPE is discarded without overrun
        setek = 1'b1; tick(); quiet();
        sbf = 1'b1; clrope = 1'b1; faddr = 16'h0077; tick(); quiet();
        tick(); tick();
        chk1("sbfclr_busy", busy, 1'b0); chk1("sbfclr_ovr", overrun, 1'b0);
        tick();
        chk1("sbfclr_re", mem_re, 1'b0);

        // CLROPE leaves a pending erasable request alone
        setek = 1'b1; eaddr = 11'h010; tick(); quiet();
        setek = 1'b1; eaddr = 11'h020; tick(); quiet();
        clrope = 1'b1; tick(); quiet();
        tick(); tick();
        chk1("clr_e_busy", busy, 1'b1);
        tick();
        chk1("clr_e_re", mem_re, 1'b1); chk1("clr_e_sel", mem_sel, 1'b0);
        chk16("clr_e_addr", mem_addr, 16'h0020);
        repeat (4) tick();

        // random traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            rst_n  = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            setek  = ($urandom_range(0, 3) == 0);
            sbf    = ($urandom_range(0, 3) == 0);
            wen    = 1'($urandom);
            clrope = ($urandom_range(0, 7) == 0);
            eaddr  = 11'($urandom);
            faddr  = 16'($urandom);
            gem    = 16'($urandom);
            rdata  = 16'($urandom);
            model_edge();
            tick();
            chk1($sformatf("rnd%0d_re", n), mem_re, (m_age >= 1 && m_age <= RL));
            chk1($sformatf("rnd%0d_sv", n), sa_valid, (m_age == RL + 1));
            chk1($sformatf("rnd%0d_we", n), mem_we, (m_age == RL + 1) && !m_cur.fixed);
            chk1($sformatf("rnd%0d_busy", n), busy, (m_age != 0) || m_pend_v);
            chk1($sformatf("rnd%0d_ovr", n), overrun, m_ovr);
            chk16($sformatf("rnd%0d_sa", n), sa, m_sa);
            chk1($sformatf("rnd%0d_perr", n), perr, m_perr);
            if (m_age >= 1 && m_age <= RL) begin
                chk1($sformatf("rnd%0d_sel", n), mem_sel, m_cur.fixed);
                chk16($sformatf("rnd%0d_addr", n), mem_addr, m_cur.addr);
            end
            if (m_age == RL + 1 && !m_cur.fixed)
                chk16($sformatf("rnd%0d_wdata", n), mem_wdata, m_wdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_cycle_sequencer.md
MEMORY_CYCLE_SEQUENCER -- requirements
Module: memory_cycle_sequencer

Interface
REQ-001 Parameter WORD_W, default 16: sense/write word width; bit WORD_W-1 is parity, bits WORD_W-2..0 are data.
REQ-002 Parameter EADDR_W, default 11: erasable address width.
REQ-003 Parameter FADDR_W, default 16: fixed address width; SHALL be >= EADDR_W.
REQ-004 Parameter READ_LAT, default 2, range 1..8: MEM_RE cycles before read data is sampled.
REQ-005 SIM_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 SIM_RST  in  1  reset, synchronous, active-low.
REQ-007 SETEK  in  1  erasable-cycle request, sampled each edge.
REQ-008 SBF  in  1  fixed-cycle request, sampled each edge.
REQ-009 WEN  in  1  erasable write (1) or restore (0), sampled with SETEK.
REQ-010 EADDR  in  EADDR_W  erasable address, sampled with SETEK.
REQ-011 FADDR  in  FADDR_W  fixed address, sampled with SBF.
REQ-012 GEM  in  WORD_W  write data, sampled with SETEK; its parity bit is ignored.
REQ-013 CLROPE  in  1  cancel a pending fixed request.
REQ-014 MEM_SEL  out  1  0 = erasable array, 1 = fixed array.
REQ-015 MEM_ADDR  out  FADDR_W  array address; erasable addresses are zero-extended.
REQ-016 MEM_RE  out  1  array read strobe.
REQ-017 MEM_WE  out  1  erasable write strobe.
REQ-018 MEM_WDATA  out  WORD_W  erasable write word.
REQ-019 MEM_RDATA  in  WORD_W  array read word.
REQ-020 SA  out  WORD_W  sensed word, held until the next sense.
REQ-021 SA_VALID  out  1  one-cycle pulse marking a new SA.
REQ-022 PERR  out  1  parity error for the current SA.
REQ-023 BUSY  out  1  asserted when state is not IDLE or the pending slot is full.
REQ-024 OVERRUN  out  1  sticky flag for a dropped request.

Function
REQ-025 FSM states SHALL be IDLE, E_READ, E_WRITE, F_READ, F_SENSE; all outputs SHALL be registered.
REQ-026 Erasable cycle: SETEK sampled at edge k from IDLE SHALL give E_READ for cycles k+1..k+READ_LAT (MEM_SEL=0, MEM_RE=1), then E_WRITE at k+READ_LAT+1, then IDLE.
REQ-027 MEM_RDATA SHALL be sampled at the end of the last E_READ or F_READ cycle; SA and SA_VALID=1 SHALL appear in the following cycle (E_WRITE or F_SENSE).
REQ-028 E_WRITE SHALL assert MEM_WE for exactly one cycle, with MEM_RE=0.
REQ-029 In E_WRITE, MEM_WDATA SHALL be the sampled read word unchanged if WEN=0.
REQ-030 In E_WRITE, MEM_WDATA SHALL be the GEM data bits with a regenerated odd-parity bit if WEN=1.
REQ-031 Fixed cycle: SBF gives F_READ for READ_LAT cycles (MEM_SEL=1, MEM_RE=1), then one F_SENSE cycle, then IDLE; MEM_WE SHALL never assert for fixed.
REQ-032 Parity: a word is good when the count of ones across all WORD_W bits is odd.
REQ-033 PERR SHALL be updated only with SA_VALID and held until the next SA_VALID.
REQ-034 A request arriving while not IDLE SHALL be stored with its address/data in a one-deep pending slot.
REQ-035 The pending request SHALL launch from the first IDLE cycle, entering its READ state on the next edge.
REQ-036 SETEK and SBF together in IDLE: the erasable cycle SHALL start and the fixed request SHALL become pending.
REQ-037 A request arriving while the pending slot is full SHALL be dropped and SHALL set OVERRUN; OVERRUN clears only on reset.
REQ-038 CLROPE SHALL empty a pending fixed request.
REQ-039 SBF in the same cycle as CLROPE SHALL be discarded and SHALL NOT set OVERRUN.
REQ-040 CLROPE SHALL have no effect on a pending erasable request or on a cycle in progress.

Reset
REQ-041 SIM_RST=0 at an edge SHALL force IDLE and empty the pending slot, including mid-cycle; an interrupted erasable cycle SHALL NOT write.
REQ-042 Reset values: SA=0, SA_VALID=0, PERR=0, BUSY=0, OVERRUN=0, MEM_SEL=0, MEM_ADDR=0, MEM_RE=0, MEM_WE=0, MEM_WDATA=0.

Structure
REQ-043 Package memory_cycle_pkg SHALL hold the state enum, the odd-parity function and the parameter defaults.
REQ-044 The one-deep pending slot SHALL be a sub-module mem_req_slot (kind, address, WEN, data, full flag).
REQ-045 The implementation SHALL be a single FSM plus one READ_LAT cycle counter.

Verification (WORD_W=16, READ_LAT=2)
REQ-046 SETEK at k, EADDR=0x123, WEN=0, MEM_RDATA=0x0001 -> MEM_ADDR=0x0123 with MEM_RE at k+1..k+2; SA=0x0001, SA_VALID, MEM_WE, MEM_WDATA=0x0001 at k+3; PERR=0; BUSY=0 at k+4.
REQ-047 SETEK with WEN=1, GEM=0x0003 -> MEM_WDATA=0x8003 in E_WRITE.
REQ-048 SETEK and SBF together at k, FADDR=0xABCD -> erasable completes at k+3; MEM_SEL=1, MEM_ADDR=0xABCD, MEM_RE at k+5..k+6; SA_VALID at k+7.
REQ-049 SETEK at k, then SBF at k+1 and SETEK at k+2 -> the second SETEK is dropped; OVERRUN=1 and stays 1; the fixed cycle runs.
REQ-050 MEM_RDATA=0x0003 on a fixed read -> SA=0x0003 and PERR=1 with SA_VALID.
REQ-051 SIM_RST=0 for one cycle at k+1 during an erasable cycle -> IDLE, MEM_RE=0, no MEM_WE, no SA_VALID, BUSY=0.
